// File: rtl/riscv_dmem_responder_pkg.sv
// Shared constants, request bundle and range helper for the data-memory responder.
package riscv_dmem_responder_pkg;

  localparam int DMEM_XLEN       = 32;
  localparam int DMEM_DEPTH_DEF  = 1024;
  localparam int WAIT_CYCLES_DEF = 2;

  localparam logic [1:0] DMEM_ST_IDLE = 2'd0;
  localparam logic [1:0] DMEM_ST_WAIT = 2'd1;
  localparam logic [1:0] DMEM_ST_RESP = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  byte_sel;
    logic [31:0] wr_data;
  } dmem_req_t;

  // Word index must fall inside the array; byte offset bits are not part of the check.
  function automatic logic dmem_in_range(input logic [29:0] word_addr, input int unsigned depth);
    return {2'b00, word_addr} < depth;
  endfunction

endpackage

// File: rtl/riscv_dmem_responder_if.sv
// Data-memory request/response bundle between the load/store unit and the responder.
interface riscv_dmem_responder_if
  import riscv_dmem_responder_pkg::*;
#(
  parameter int XLEN = DMEM_XLEN
);
  logic              dmem_req;
  logic [XLEN-1:0]   dmem_addr;
  logic              dmem_wen;
  logic [XLEN/8-1:0] dmem_byte_sel;
  logic [XLEN-1:0]   dmem_wr_data;
  logic [XLEN-1:0]   dmem_rd_data;
  logic              dmem_ack;
  logic              dmem_err;
  logic              dmem_busy;

  modport master (
    output dmem_req, dmem_addr, dmem_wen, dmem_byte_sel, dmem_wr_data,
    input  dmem_rd_data, dmem_ack, dmem_err, dmem_busy
  );

  modport slave (
    input  dmem_req, dmem_addr, dmem_wen, dmem_byte_sel, dmem_wr_data,
    output dmem_rd_data, dmem_ack, dmem_err, dmem_busy
  );
endinterface

// File: rtl/riscv_dmem_responder_ram.sv
// Byte-lane word storage: synchronous byte-enabled write, enabled registered read, no reset.
module riscv_dmem_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [XLEN/8-1:0] byte_sel,
  input  logic [XLEN-1:0]   wr_data,
  output logic [XLEN-1:0]   rd_data
);

  // One narrow array per lane keeps each lane a plain single-port memory.
  for (genvar gi = 0; gi < XLEN/8; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rd_reg;

    always_ff @(posedge clk) begin
      if (we && byte_sel[gi]) begin
        lane_mem[addr] <= wr_data[gi*8 +: 8];
      end
      if (re) begin
        lane_rd_reg <= lane_mem[addr];
      end
    end

    assign rd_data[gi*8 +: 8] = lane_rd_reg;
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Slow-SRAM model for the CPU data path: registers a request, waits WAIT_CYCLES,
// performs the access and returns a one-cycle acknowledge.
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int XLEN        = DMEM_XLEN,
  parameter int DMEM_DEPTH  = DMEM_DEPTH_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  riscv_dmem_responder_if.slave dmem
);

  localparam int AW = $clog2(DMEM_DEPTH);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]      state_reg;
  logic [CW-1:0]   cnt_reg;
  dmem_req_t       req_reg;
  logic            ack_reg;
  logic            err_reg;
  logic            busy_reg;
  logic            rd_valid_reg;

  dmem_req_t       req_in;
  dmem_req_t       acc;
  logic            access;
  logic            acc_in_range;
  logic            ram_we;
  logic            ram_re;
  logic [XLEN-1:0] ram_rd_data;
  logic            unused_addr_lsb;

  // With zero wait states the access happens on the accepting edge, so it
  // must use the live request rather than the not-yet-loaded registers.
  always_comb begin
    req_in = '{addr: dmem.dmem_addr, wen: dmem.dmem_wen,
               byte_sel: dmem.dmem_byte_sel, wr_data: dmem.dmem_wr_data};
    acc    = (state_reg == DMEM_ST_IDLE) ? req_in : req_reg;
    access = 1'b0;
    if (state_reg == DMEM_ST_IDLE) begin
      access = dmem.dmem_req && (WAIT_CYCLES == 0);
    end else if (state_reg == DMEM_ST_WAIT) begin
      access = (cnt_reg == CNT_ONE);
    end
    access = access && i_rstn;
  end

  assign acc_in_range    = dmem_in_range(acc.addr[31:2], DMEM_DEPTH);
  assign ram_we          = access && acc.wen && acc_in_range;
  assign ram_re          = access && !acc.wen && acc_in_range;
  assign unused_addr_lsb = ^acc.addr[1:0];

  riscv_dmem_ram #(
    .XLEN  (XLEN),
    .DEPTH (DMEM_DEPTH)
  ) u_ram (
    .clk      (i_clk),
    .we       (ram_we),
    .re       (ram_re),
    .addr     (acc.addr[AW+1:2]),
    .byte_sel (acc.byte_sel),
    .wr_data  (acc.wr_data),
    .rd_data  (ram_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg    <= DMEM_ST_IDLE;
      cnt_reg      <= '0;
      req_reg      <= '0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      case (state_reg)
        DMEM_ST_IDLE: begin
          if (dmem.dmem_req) begin
            req_reg   <= req_in;
            cnt_reg   <= CNT_LOAD;
            busy_reg  <= 1'b1;
            state_reg <= (WAIT_CYCLES == 0) ? DMEM_ST_RESP : DMEM_ST_WAIT;
          end
        end
        DMEM_ST_WAIT: begin
          if (cnt_reg == CNT_ONE) begin
            state_reg <= DMEM_ST_RESP;
          end
          cnt_reg <= cnt_reg - CNT_ONE;
        end
        DMEM_ST_RESP: begin
          state_reg <= DMEM_ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= DMEM_ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase

      // Reads and any out-of-range access replace the returned word; good writes keep it.
      if (access) begin
        ack_reg <= 1'b1;
        err_reg <= !acc_in_range;
        if (!acc.wen || !acc_in_range) begin
          rd_valid_reg <= acc_in_range;
        end
      end
    end
  end

  assign dmem.dmem_ack     = ack_reg;
  assign dmem.dmem_err     = err_reg;
  assign dmem.dmem_busy    = busy_reg;
  assign dmem.dmem_rd_data = rd_valid_reg ? ram_rd_data : '0;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Scoreboard bench: randomized accesses against a word-array model, plus a zero-wait-state instance.
module tb_riscv_dmem_responder;

  localparam int WC    = 2;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_rd  = '0;
  logic        last_err = 1'b0;
  logic [31:0] pool [9];

  riscv_dmem_responder_if #(.XLEN(32)) bus  ();
  riscv_dmem_responder_if #(.XLEN(32)) bus0 ();

  riscv_dmem_responder #(.XLEN(32), .DMEM_DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .dmem   (bus)
  );

  riscv_dmem_responder #(.XLEN(32), .DMEM_DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .dmem   (bus0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Reference: byte-lane merge for writes, whole word for reads, zero + err out of range.
  function automatic exp_t model_apply(input logic [31:0] a, input logic w,
                                       input logic [3:0] be, input logic [31:0] d);
    exp_t e;
    logic [29:0] widx;
    widx = a[31:2];
    if (widx >= 30'(DEPTH)) begin
      last_rd  = '0;
      last_err = 1'b1;
    end else begin
      last_err = 1'b0;
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mem_m[widx[9:0]][i*8 +: 8] = d[i*8 +: 8];
      end else begin
        last_rd = mem_m[widx[9:0]];
      end
    end
    e.rd  = last_rd;
    e.err = last_err;
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: every ack must match the oldest outstanding expectation, including its cycle.
  always @(negedge clk) begin
    if (rst_n && bus.dmem_ack) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=ack required=no_ack (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_rd_data", bus.dmem_rd_data, mon_e.rd);
        chk1("ack_err", bus.dmem_err, mon_e.err);
        chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
        $display("ack cyc=%0d rd=0x%08h err=%0b", cyc, bus.dmem_rd_data, bus.dmem_err);
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] be, input logic [31:0] d);
    bus.dmem_req      = 1'b1;
    bus.dmem_addr     = a;
    bus.dmem_wen      = w;
    bus.dmem_byte_sel = be;
    bus.dmem_wr_data  = d;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0) return;
    end
    checks++;
    failures++;
    $display("FAIL ack_timeout pending=%0d required=0", sb.size());
    sb.delete();
  endtask

  task automatic access(input logic [31:0] a, input logic w, input logic [3:0] be, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    drive(a, w, be, d);
    @(negedge clk);
    chk1("busy_in_wait", bus.dmem_busy, 1'b1);
    e     = model_apply(a, w, be, d);
    e.cyc = cyc + WC;
    sb.push_back(e);
    bus.dmem_req = 1'b0;
    drain();
    @(negedge clk);
    chk("rd_data_hold", bus.dmem_rd_data, last_rd);
    chk1("err_hold", bus.dmem_err, last_err);
    chk1("busy_idle", bus.dmem_busy, 1'b0);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        w;
    logic [31:0] op_d [4];
    logic        op_w [4];
    logic [31:0] exp0 [4];

    bus.dmem_req = 1'b0;  bus.dmem_addr = '0;  bus.dmem_wen = 1'b0;
    bus.dmem_byte_sel = '0;  bus.dmem_wr_data = '0;
    bus0.dmem_req = 1'b0; bus0.dmem_addr = '0; bus0.dmem_wen = 1'b0;
    bus0.dmem_byte_sel = '0; bus0.dmem_wr_data = '0;
    for (int i = 0; i < 8; i++) pool[i] = 32'h100 + 32'(i * 4);
    pool[8] = 32'hFFC;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk1("reset_ack", bus.dmem_ack, 1'b0);
    chk1("reset_err", bus.dmem_err, 1'b0);
    chk1("reset_busy", bus.dmem_busy, 1'b0);
    chk("reset_rd_data", bus.dmem_rd_data, 32'h0);
    rst_n = 1'b1;

    // Directed: full write/read, partial lane write, out-of-range, zero byte_sel, last word.
    access(32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
    access(32'h10, 1'b0, 4'h0, 32'h0);
    access(32'h10, 1'b1, 4'b0100, 32'h00AA0000);
    access(32'h10, 1'b0, 4'h0, 32'h0);
    access(32'h0, 1'b1, 4'hF, 32'hCAFEF00D);
    access(32'h1000, 1'b1, 4'hF, 32'h12345678);
    access(32'h0, 1'b0, 4'h0, 32'h0);
    access(32'h1000, 1'b0, 4'h0, 32'h0);
    access(32'h0, 1'b1, 4'h0, 32'hFFFFFFFF);
    access(32'h0, 1'b0, 4'h0, 32'h0);
    access(32'h20, 1'b1, 4'hF, 32'h20202020);
    access(32'h30, 1'b1, 4'hF, 32'h11111111);
    for (int i = 0; i < 9; i++) access(pool[i], 1'b1, 4'hF, $urandom());
    access(32'hFFC, 1'b0, 4'h0, 32'h0);

    // Reset while a write to 0x30 is still waiting: write discarded, outputs cleared.
    @(negedge clk);
    drive(32'h30, 1'b1, 4'hF, 32'h22222222);
    @(negedge clk);
    bus.dmem_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk1("midwait_rst_ack", bus.dmem_ack, 1'b0);
    chk1("midwait_rst_err", bus.dmem_err, 1'b0);
    chk1("midwait_rst_busy", bus.dmem_busy, 1'b0);
    chk("midwait_rst_rd_data", bus.dmem_rd_data, 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    last_rd  = '0;
    last_err = 1'b0;
    access(32'h30, 1'b0, 4'h0, 32'h0);

    // Request to 0x20 raised during WAIT and dropped before IDLE: never served.
    @(negedge clk);
    drive(32'h10, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    e = model_apply(32'h10, 1'b0, 4'h0, 32'h0);
    e.cyc = cyc + WC;
    sb.push_back(e);
    drive(32'h20, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    bus.dmem_req = 1'b0;
    drain();
    repeat (6) @(negedge clk);

    // Same, but held: accepted on the first edge back in IDLE.
    @(negedge clk);
    drive(32'h10, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    e = model_apply(32'h10, 1'b0, 4'h0, 32'h0);
    e.cyc = cyc + WC;
    sb.push_back(e);
    drive(32'h20, 1'b0, 4'h0, 32'h0);
    repeat (WC + 2) @(negedge clk);
    e = model_apply(32'h20, 1'b0, 4'h0, 32'h0);
    e.cyc = cyc + WC;
    sb.push_back(e);
    bus.dmem_req = 1'b0;
    drain();
    @(negedge clk);

    // Randomized mix of in-range pool words and out-of-range addresses.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 99) < 20) a = $urandom() | 32'h0000_1000;
      else a = {pool[$urandom_range(0, 8)][31:2], 2'($urandom_range(0, 3))};
      w  = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      d  = $urandom();
      access(a, w, be, d);
    end

    // Zero wait states with req held: ack every second cycle.
    op_w[0] = 1'b1; op_d[0] = 32'hA5A50F0F;
    op_w[1] = 1'b0; op_d[1] = 32'h0;
    op_w[2] = 1'b1; op_d[2] = 32'h5A5AF0F0;
    op_w[3] = 1'b0; op_d[3] = 32'h0;
    exp0[0] = 32'h0; exp0[1] = op_d[0]; exp0[2] = op_d[0]; exp0[3] = op_d[2];
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk1("w0_ack", bus0.dmem_ack, 1'(k % 2));
        if (k % 2 == 1) begin
          chk("w0_rd_data", bus0.dmem_rd_data, exp0[k/2]);
          chk1("w0_err", bus0.dmem_err, 1'b0);
          $display("w0 ack k=%0d rd=0x%08h", k, bus0.dmem_rd_data);
        end
      end
      if (k == 0 || k % 2 == 1) begin
        if ((k + 1) / 2 < 4) begin
          bus0.dmem_req      = 1'b1;
          bus0.dmem_addr     = 32'h40;
          bus0.dmem_wen      = op_w[(k + 1) / 2];
          bus0.dmem_byte_sel = 4'hF;
          bus0.dmem_wr_data  = op_d[(k + 1) / 2];
        end else begin
          bus0.dmem_req = 1'b0;
        end
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
